// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : shared pipeline metadata types for the hazard controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
    } stage_meta_t;

    localparam stage_meta_t STAGE_BUBBLE = '{
        valid:    1'b0,
        rd:       5'd0,
        regwrite: 1'b0,
        memread:  1'b0,
        memwrite: 1'b0
    };

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hc_state_e;

    function automatic logic accesses_mem(input stage_meta_t m);
        return m.valid && (m.memread || m.memwrite);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if : decode/memory inputs and hold/flush/forwarding outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_memwrite;
    logic             ex_branch_taken;
    logic             dmem_ready;

    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             ex_hold;
    logic             mem_hold;
    logic [4:0]       EXMEM_RegisterRd;
    logic [4:0]       MEMWB_RegisterRd;
    logic             EXMEM_RegWrite;
    logic             MEMWB_RegWrite;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_regwrite, id_memread, id_memwrite, ex_branch_taken, dmem_ready,
        input  pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold, mem_hold,
               EXMEM_RegisterRd, MEMWB_RegisterRd, EXMEM_RegWrite, MEMWB_RegWrite,
               mem_timeout, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_regwrite, id_memread, id_memwrite, ex_branch_taken, dmem_ready,
        output pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold, mem_hold,
               EXMEM_RegisterRd, MEMWB_RegisterRd, EXMEM_RegWrite, MEMWB_RegWrite,
               mem_timeout, stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect : flags an ID instruction reading the rd of a load in EX
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_use_detect
    import riscv_pkg::*;
(
    input  stage_meta_t idex,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    output logic        hazard
);
    logic load_in_ex;
    logic src_match;
    logic unused_idex;

    // x0 never carries a real dependency, so a load to x0 cannot stall
    assign load_in_ex  = idex.valid && idex.memread && (idex.rd != 5'd0);
    assign src_match   = (id_rs1_used && (id_rs1 == idex.rd)) ||
                         (id_rs2_used && (id_rs2 == idex.rd));
    assign hazard      = load_in_ex && id_valid && src_match;
    assign unused_idex = ^{idex.regwrite, idex.memwrite};

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl : shadow rd tracking plus stall/flush/bubble generation
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hc
);
    localparam int                WCNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);

    stage_meta_t       idex;
    stage_meta_t       exmem;
    stage_meta_t       memwb;
    stage_meta_t       id_meta;
    hc_state_e         state;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt;
    logic              timeout;
    logic              lu_raw;
    logic              mem_wait;
    logic              branch;
    logic              load_use;
    logic              unused_memwb;

    load_use_detect u_lud (
        .idex        (idex),
        .id_valid    (hc.id_valid),
        .id_rs1      (hc.id_rs1),
        .id_rs2      (hc.id_rs2),
        .id_rs1_used (hc.id_rs1_used),
        .id_rs2_used (hc.id_rs2_used),
        .hazard      (lu_raw)
    );

    always_comb begin
        id_meta = STAGE_BUBBLE;
        if (hc.id_valid) begin
            id_meta = '{valid: 1'b1, rd: hc.id_rd, regwrite: hc.id_regwrite,
                        memread: hc.id_memread, memwrite: hc.id_memwrite};
        end
    end

    // mem-wait outranks branch, which outranks load-use
    assign mem_wait = accesses_mem(exmem) && !hc.dmem_ready;
    assign branch   = hc.ex_branch_taken && !mem_wait;
    assign load_use = lu_raw && !mem_wait && !hc.ex_branch_taken;

    assign hc.pc_hold     = mem_wait || load_use;
    assign hc.ifid_hold   = mem_wait || load_use;
    assign hc.ifid_flush  = branch;
    assign hc.idex_bubble = branch || load_use;
    assign hc.ex_hold     = mem_wait;
    assign hc.mem_hold    = mem_wait;

    assign hc.EXMEM_RegisterRd = exmem.rd;
    assign hc.MEMWB_RegisterRd = memwb.rd;
    assign hc.EXMEM_RegWrite   = exmem.valid && exmem.regwrite;
    assign hc.MEMWB_RegWrite   = memwb.valid && memwb.regwrite;
    assign hc.mem_timeout      = timeout;
    assign hc.stall_cycles     = stall_cnt;

    assign wait_cnt_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WCNT_W'(1);
    assign unused_memwb  = ^{memwb.memread, memwb.memwrite};

    always_ff @(posedge clk) begin
        if (rst) begin
            idex      <= STAGE_BUBBLE;
            exmem     <= STAGE_BUBBLE;
            memwb     <= STAGE_BUBBLE;
            state     <= RUN;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (mem_wait) begin
                // access still pending: hold it in EXMEM, retire nothing
                memwb <= STAGE_BUBBLE;
            end else begin
                memwb <= exmem;
                exmem <= idex;
                idex  <= (branch || load_use) ? STAGE_BUBBLE : id_meta;
            end

            if (hc.pc_hold && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            case (state)
                RUN: begin
                    if (mem_wait) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (hc.dmem_ready) begin
                        state <= RUN;
                    end
                    wait_cnt <= wait_cnt_next;
                    if (wait_cnt_next == WAIT_MAX) begin
                        timeout <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : directed and random stimulus, scoreboarded against a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;
    localparam int MT = 4;
    localparam int CW = 6;
    localparam int STALL_MAX = (1 << CW) - 1;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
        bit       mw;
    } meta_t;

    typedef struct {
        bit       pc_hold;
        bit       ifid_hold;
        bit       ifid_flush;
        bit       idex_bubble;
        bit       ex_hold;
        bit       mem_hold;
        bit [4:0] ex_rd;
        bit [4:0] wb_rd;
        bit       ex_rw;
        bit       wb_rw;
        bit       tmo;
        int       stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hc ();

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hc  (hc)
    );

    // reference model: pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
    meta_t pipe[3];
    int    m_stall;
    bit    m_tmo;
    bit    m_waiting;
    int    m_wait_cycles;
    bit    model_known = 1'b0;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic meta_t bubble();
        meta_t b;
        b.v = 1'b0; b.rd = 5'd0; b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0;
        return b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        m_stall = 0;
        m_tmo = 1'b0;
        m_waiting = 1'b0;
        m_wait_cycles = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit iv, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit u1, input bit u2, input bit [4:0] rd, input bit rw,
                       input bit mr, input bit mw, input bit bt, input bit rdy);
        exp_t  e;
        meta_t nw;
        bit    memwait, dep, lu, br;
        @(posedge clk);
        #1;
        rst = r;
        hc.id_valid = iv; hc.id_rs1 = rs1; hc.id_rs2 = rs2;
        hc.id_rs1_used = u1; hc.id_rs2_used = u2; hc.id_rd = rd;
        hc.id_regwrite = rw; hc.id_memread = mr; hc.id_memwrite = mw;
        hc.ex_branch_taken = bt; hc.dmem_ready = rdy;

        memwait = pipe[1].v && (pipe[1].mr || pipe[1].mw) && !rdy;
        dep = iv && pipe[0].v && pipe[0].mr && (pipe[0].rd != 0) &&
              ((u1 && rs1 == pipe[0].rd) || (u2 && rs2 == pipe[0].rd));
        br = bt && !memwait;
        lu = dep && !memwait && !bt;

        e.pc_hold = memwait || lu;   e.ifid_hold = memwait || lu;
        e.ifid_flush = br;           e.idex_bubble = br || lu;
        e.ex_hold = memwait;         e.mem_hold = memwait;
        e.ex_rd = pipe[1].rd;        e.wb_rd = pipe[2].rd;
        e.ex_rw = pipe[1].v && pipe[1].rw;
        e.wb_rw = pipe[2].v && pipe[2].rw;
        e.tmo = m_tmo;               e.stall = m_stall;
        if (model_known) sb.push_back(e);

        if (r) begin
            model_reset();
            model_known = 1'b1;
        end else begin
            if (memwait) begin
                pipe[2] = bubble();
            end else begin
                nw = bubble();
                if (iv && !br && !lu) begin
                    nw.v = 1'b1; nw.rd = rd; nw.rw = rw; nw.mr = mr; nw.mw = mw;
                end
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = nw;
            end
            if (e.pc_hold && m_stall < STALL_MAX) m_stall++;
            if (m_waiting) begin
                if (m_wait_cycles < MT) m_wait_cycles++;
                if (m_wait_cycles == MT) m_tmo = 1'b1;
            end else if (memwait) begin
                m_wait_cycles = 0;
            end
            m_waiting = memwait;
        end
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // monitor: every cycle the DUT presents a full set of outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_hold",      32'(hc.pc_hold),          32'(e.pc_hold));
                chk("ifid_hold",    32'(hc.ifid_hold),        32'(e.ifid_hold));
                chk("ifid_flush",   32'(hc.ifid_flush),       32'(e.ifid_flush));
                chk("idex_bubble",  32'(hc.idex_bubble),      32'(e.idex_bubble));
                chk("ex_hold",      32'(hc.ex_hold),          32'(e.ex_hold));
                chk("mem_hold",     32'(hc.mem_hold),         32'(e.mem_hold));
                chk("exmem_rd",     32'(hc.EXMEM_RegisterRd), 32'(e.ex_rd));
                chk("memwb_rd",     32'(hc.MEMWB_RegisterRd), 32'(e.wb_rd));
                chk("exmem_rw",     32'(hc.EXMEM_RegWrite),   32'(e.ex_rw));
                chk("memwb_rw",     32'(hc.MEMWB_RegWrite),   32'(e.wb_rw));
                chk("mem_timeout",  32'(hc.mem_timeout),      32'(e.tmo));
                chk("stall_cycles", 32'(hc.stall_cycles),     32'(e.stall));
            end
        end
    end

    initial begin
        bit [1:0] op;
        rst = 1'b1;
        hc.id_valid = 1'b0; hc.id_rs1 = '0; hc.id_rs2 = '0;
        hc.id_rs1_used = 1'b0; hc.id_rs2_used = 1'b0; hc.id_rd = '0;
        hc.id_regwrite = 1'b0; hc.id_memread = 1'b0; hc.id_memwrite = 1'b0;
        hc.ex_branch_taken = 1'b0; hc.dmem_ready = 1'b1;
        do_reset();
        do_reset();
        idle(1'b1);

        // lw x5 then add x6,x5,x7: one stall, then the load reaches MEM/WB
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 1);
        cyc(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0, 1);
        cyc(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0, 1);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // lw x0 then add x6,x0,x0: no stall
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 1);
        cyc(0, 1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0, 0, 1);
        idle(1'b1); idle(1'b1);

        // load-use coinciding with a taken branch
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 1);
        cyc(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 1, 1);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // sw stalled 3 cycles in EX/MEM from a clean reset
        do_reset();
        cyc(0, 1, 5'd2, 5'd3, 1, 1, 5'd0, 0, 0, 1, 0, 1);
        idle(1'b1);
        idle(1'b0); idle(1'b0); idle(1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // wait overrun: 6 low cycles against MEM_TIMEOUT=4
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, 1);
        idle(1'b1);
        repeat (6) idle(1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // reset on the second WAIT cycle
        do_reset();
        cyc(0, 1, 5'd0, 5'd0, 1, 0, 5'd4, 1, 0, 1, 0, 1);
        idle(1'b1);
        idle(1'b0); idle(1'b0);
        do_reset();
        idle(1'b1); idle(1'b1);

        for (int n = 0; n < 3000; n++) begin
            op = 2'($urandom_range(0, 3));
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 85),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)),
                (op != 2'd2), (op == 2'd1), (op == 2'd2),
                ($urandom_range(0, 99) < 10),
                ($urandom_range(0, 99) < 75));
        end
        idle(1'b1); idle(1'b1);
        repeat (2) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
